// File: rtl/cyclic_encoder_stream_pkg.sv
// Shared FSM state type and named generator polynomials
// for the serial systematic cyclic encoder.
package cyclic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic [4:0] POLY_X4_X_1 = 5'b10011;
  localparam logic [3:0] POLY_X3_X_1 = 4'b1011;

endpackage

// File: rtl/cyclic_encoder_stream_if.sv
// Serial in/out valid-ready bundle for the cyclic encoder.
// The encoder takes the slave side, its driver the master side.
interface cyclic_encoder_stream_if;

  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_sop;
  logic out_eop;
  logic out_ready;

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit,
    output out_sop, out_eop
  );

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit,
    input  out_sop, out_eop
  );

endinterface

// File: rtl/cyclic_encoder_stream_lfsr.sv
// Division remainder register: divides by GEN_POLY while gated,
// plain zero-fill shift otherwise so parity bits can be read out.
module cyclic_lfsr #(
  parameter int         R        = 4,
  parameter logic [R:0] GEN_POLY = 5'b10011
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift_in,
  input  logic gate,
  input  logic clear,
  output logic msb
);

  logic [R-1:0] lfsr_q;
  logic [R-1:0] lfsr_d;
  logic [R-1:0] shifted;
  logic         fb;

  always_comb begin
    fb      = gate & (shift_in ^ lfsr_q[R-1]);
    shifted = lfsr_q << 1;
    lfsr_d  = shifted ^ (fb ? GEN_POLY[R-1:0] : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else if (clear) begin
      lfsr_q <= '0;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign msb = lfsr_q[R-1];

endmodule

// File: rtl/cyclic_encoder_stream.sv
// Serial systematic (N,K) cyclic encoder: K data bits pass
// through, then N-K parity bits, behind one output register.
module cyclic_encoder_stream
  import cyclic_pkg::*;
#(
  parameter int             N        = 15,
  parameter int             K        = 11,
  parameter logic [N-K:0]   GEN_POLY = POLY_X4_X_1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  cyclic_encoder_stream_if.slave  io
);

  localparam int R  = N - K;
  localparam int CW = $clog2(N);

  if (N <= K) begin : g_chk_nk
    $error("N must exceed K");
  end
  if (K <= 0) begin : g_chk_k
    $error("K must be positive");
  end
  if (!GEN_POLY[0] || !GEN_POLY[N-K]) begin : g_chk_poly
    $error("GEN_POLY end bits must be 1");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            free, in_xfer, par_step;
  logic            last_data, last_par;
  logic            lfsr_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      in_xfer: begin
        cnt_d   = (state_q == IDLE) ? CW'(1)
                                    : cnt_q + 1'b1;
        state_d = last_data ? PARITY : DATA;
      end
      par_step: begin
        cnt_d   = last_par ? '0 : cnt_q + 1'b1;
        state_d = last_par ? IDLE : PARITY;
      end
      default: ;
    endcase
  end

  // Stall gating: nothing advances unless the output slot frees up.
  always_comb begin
    free        = !out_valid_q || io.out_ready;
    io.in_ready = enable && (state_q != PARITY) && free;
    in_xfer     = io.in_valid && io.in_ready;
    par_step    = enable && (state_q == PARITY) && free;
    last_data   = (state_q == IDLE) ? (K == 1)
                                    : (cnt_q == CW'(K - 1));
    last_par    = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    if (enable && free) begin
      out_valid_d = in_xfer || par_step;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      if (in_xfer) begin
        out_bit_d = io.in_bit;
        sop_d     = (state_q == IDLE);
      end else if (par_step) begin
        out_bit_d = lfsr_msb;
        eop_d     = last_par;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_bit   = out_bit_q;
  assign io.out_sop   = sop_q;
  assign io.out_eop   = eop_q;

  cyclic_lfsr #(
    .R        (R),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (in_xfer || par_step),
    .shift_in (io.in_bit),
    .gate     (in_xfer),
    .clear    (par_step && last_par),
    .msb      (lfsr_msb)
  );

endmodule

// File: tb/tb_cyclic_encoder_stream.sv
// Directed and random frames on a (15,11) and a (7,4) encoder,
// checked against polynomial long division.
module tb_cyclic_encoder_stream;

  logic clk = 1'b0;
  logic rst;
  int   act;
  logic en, vin, bin, ordy;
  int   pass_n = 0;
  int   total_n = 0;

  always #5 clk = ~clk;

  cyclic_encoder_stream_if a_if ();
  cyclic_encoder_stream_if b_if ();

  logic en_a, en_b;
  logic ov, ob, osop, oeop, irdy;

  assign en_a = (act == 0) ? en : 1'b1;
  assign en_b = (act == 1) ? en : 1'b1;

  assign a_if.in_valid  = (act == 0) && vin;
  assign a_if.in_bit    = bin;
  assign a_if.out_ready = (act == 0) ? ordy : 1'b1;
  assign b_if.in_valid  = (act == 1) && vin;
  assign b_if.in_bit    = bin;
  assign b_if.out_ready = (act == 1) ? ordy : 1'b1;

  assign ov   = act ? b_if.out_valid : a_if.out_valid;
  assign ob   = act ? b_if.out_bit   : a_if.out_bit;
  assign osop = act ? b_if.out_sop   : a_if.out_sop;
  assign oeop = act ? b_if.out_eop   : a_if.out_eop;
  assign irdy = act ? b_if.in_ready  : a_if.in_ready;

  cyclic_encoder_stream u_a (
    .clk    (clk),
    .rst    (rst),
    .enable (en_a),
    .io     (a_if)
  );

  cyclic_encoder_stream #(
    .N        (7),
    .K        (4),
    .GEN_POLY (4'b1011)
  ) u_b (
    .clk    (clk),
    .rst    (rst),
    .enable (en_b),
    .io     (b_if)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp);
    total_n++;
    if (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [14:0] ref_cw(
    input int n, input int k,
    input logic [4:0] g, input logic [14:0] d);
    logic [29:0] m;
    int r;
    r = n - k;
    m = {15'd0, d} << r;
    for (int b = n - 1; b >= r; b--)
      if (m[b]) m = m ^ ({25'd0, g} << (b - r));
    return (d << r) | m[14:0];
  endfunction

  task automatic run_frame(
    input int sel, input logic [14:0] d,
    input int mode, input bit vgap,
    input int frz, input int stop_after);
    int n, k, i, cyc, got, sent;
    logic [14:0] cw, sopv, eopv, exp_cw;
    logic snap_v, snap_b, snap_s, snap_e;
    act = sel;
    n = sel ? 7 : 15;
    k = sel ? 4 : 11;
    exp_cw = ref_cw(n, k, sel ? 5'b01011 : 5'b10011, d);
    i = k - 1;
    cyc = 0; got = 0; sent = 0;
    cw = '0; sopv = '0; eopv = '0;
    snap_v = 0; snap_b = 0; snap_s = 0; snap_e = 0;
    while (got < n && cyc < 400 && sent != stop_after) begin
      @(posedge clk); #1;
      en = !(cyc >= frz && cyc < frz + 5);
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = (cyc % 3 != 2);
        default: ordy = ($urandom_range(0, 3) != 0);
      endcase
      vin = (i >= 0) && (!vgap || $urandom_range(0, 2) != 0);
      bin = (i >= 0) ? d[i] : 1'($urandom);
      if (cyc == frz) begin
        snap_v = ov; snap_b = ob;
        snap_s = osop; snap_e = oeop;
      end
      @(negedge clk);
      if (!en) begin
        chk("frz_valid", ov, snap_v);
        chk("frz_bit", ob, snap_b);
        chk("frz_sop", osop, snap_s);
        chk("frz_eop", oeop, snap_e);
        chk("frz_in_ready", irdy, 1'b0);
      end
      if (ov && !ordy) chk("stall_in_ready", irdy, 1'b0);
      if (vin && irdy) begin
        i--;
        sent++;
      end
      if (ov && ordy && en) begin
        cw   = {cw[13:0], ob};
        sopv = {sopv[13:0], osop};
        eopv = {eopv[13:0], oeop};
        got++;
      end
      cyc++;
    end
    if (stop_after < 0) begin
      chk("frame_done", got, n);
      chk("codeword", cw, exp_cw);
      chk("sop", sopv, 15'd1 << (n - 1));
      chk("eop", eopv, 15'd1);
    end
  endtask

  initial begin
    act = 0; rst = 1'b1; en = 1'b1;
    vin = 1'b0; bin = 1'b0; ordy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_out_bit", ob, 1'b0);
    chk("rst_out_sop", osop, 1'b0);
    chk("rst_out_eop", oeop, 1'b0);
    chk("rst_in_ready", irdy, 1'b1);
    chk("rst_b_valid", b_if.out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(0, 15'h400, 0, 0, 1000, -1);
    run_frame(0, 15'h001, 0, 0, 1000, -1);
    run_frame(0, 15'h000, 0, 0, 1000, -1);
    run_frame(0, 15'h400, 1, 0, 1000, -1);
    run_frame(0, 15'h5A5, 1, 1, 1000, -1);

    run_frame(0, 15'h2B7, 0, 0, 1000, 6);
    @(posedge clk); #1;
    vin = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", ov, 1'b0);
    chk("midrst_sop", osop, 1'b0);
    repeat (2) @(negedge clk);
    chk("midrst_hold_valid", ov, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(0, 15'h001, 0, 0, 1000, -1);

    run_frame(1, 15'h008, 0, 0, 5, -1);
    run_frame(1, 15'h00D, 1, 0, 1000, -1);

    for (int f = 0; f < 1000; f++) begin
      if (f % 4 == 3)
        run_frame(1, 15'($urandom) & 15'h00F, 2, 1, 1000, -1);
      else
        run_frame(0, 15'($urandom) & 15'h7FF, 2, 1, 1000, -1);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
